// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the L1-to-memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic {
      IC = 1'b0,
      DC = 1'b1
   } req_id_e;

   localparam int ADDR_W_DEF    = 64;
   localparam int LINE_W_DEF    = 512;
   localparam int OFFSET_W_DEF  = 6;
   localparam int MAX_OUTST_DEF = 4;

   function automatic logic [ADDR_W_DEF-1:0] line_align(
      input logic [ADDR_W_DEF-1:0] a,
      input int unsigned           off_w
   );
      logic [ADDR_W_DEF-1:0] m;
      m = '1 << off_w;
      return a & m;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side channels of the memory port arbiter.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LINE_W    = LINE_W_DEF,
   parameter int MAX_OUTST = MAX_OUTST_DEF
);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic              ic_req_valid_i;
   logic              ic_req_ready_o;
   logic [ADDR_W-1:0] ic_req_addr_i;
   logic              ic_resp_valid_o;
   logic              ic_resp_ready_i;
   logic [LINE_W-1:0] ic_resp_data_o;

   logic              dc_req_valid_i;
   logic              dc_req_ready_o;
   logic [ADDR_W-1:0] dc_req_addr_i;
   logic              dc_req_we_i;
   logic [LINE_W-1:0] dc_req_wdata_i;
   logic              dc_resp_valid_o;
   logic              dc_resp_ready_i;
   logic [LINE_W-1:0] dc_resp_data_o;

   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic              mem_req_we_o;
   logic [LINE_W-1:0] mem_req_wdata_o;
   logic              mem_resp_valid_i;
   logic              mem_resp_ready_o;
   logic [LINE_W-1:0] mem_resp_data_i;

   logic [CNT_W-1:0]  outst_cnt_o;

   modport slave (
      input  ic_req_valid_i, ic_req_addr_i, ic_resp_ready_i,
      output ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
      input  dc_req_valid_i, dc_req_addr_i, dc_req_we_i,
      input  dc_req_wdata_i, dc_resp_ready_i,
      output dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
      input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      output mem_req_valid_o, mem_req_addr_o, mem_req_we_o,
      output mem_req_wdata_o, mem_resp_ready_o, outst_cnt_o
   );

   modport master (
      output ic_req_valid_i, ic_req_addr_i, ic_resp_ready_i,
      input  ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
      output dc_req_valid_i, dc_req_addr_i, dc_req_we_i,
      output dc_req_wdata_i, dc_resp_ready_i,
      input  dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
      output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o,
      input  mem_req_wdata_o, mem_resp_ready_o, outst_cnt_o
   );

endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory requests.
module id_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter  int DEPTH = MAX_OUTST_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  req_id_e       push_id_i,
   input  logic          pop_i,
   output req_id_e       head_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   req_id_e       mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= push_id_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache,
// with in-order response routing through a requester-ID FIFO.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LINE_W    = LINE_W_DEF,
   parameter int OFFSET_W  = OFFSET_W_DEF,
   parameter int MAX_OUTST = MAX_OUTST_DEF
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);

   localparam int CW = $clog2(MAX_OUTST) + 1;

   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [LINE_W-1:0] wd_q, wd_d;
   req_id_e           last_q, last_d;
   req_id_e           grant;
   req_id_e           head;
   logic              empty;
   logic [CW-1:0]     cnt;
   logic              slot_free, can_issue;
   logic              ic_rdy, dc_rdy, push, pop;
   logic              ic_rv, dc_rv, mrr;
   logic [ADDR_W-1:0] sel_addr;

   // Readies are forced low while reset is held so nothing is accepted.
   assign slot_free = !vld_q || bus.mem_req_ready_i;
   assign can_issue = !rst && slot_free && (cnt < CW'(MAX_OUTST));

   always_comb begin
      grant = IC;
      unique case (1'b1)
         bus.ic_req_valid_i && bus.dc_req_valid_i:
            grant = (last_q == DC) ? IC : DC;
         !bus.ic_req_valid_i && bus.dc_req_valid_i:
            grant = DC;
         default:
            grant = IC;
      endcase
   end

   assign ic_rdy   = can_issue && bus.ic_req_valid_i && (grant == IC);
   assign dc_rdy   = can_issue && bus.dc_req_valid_i && (grant == DC);
   assign push     = ic_rdy || dc_rdy;
   assign sel_addr = (grant == IC) ? bus.ic_req_addr_i : bus.dc_req_addr_i;

   always_comb begin
      vld_d  = vld_q;
      addr_d = addr_q;
      we_d   = we_q;
      wd_d   = wd_q;
      last_d = last_q;
      if (push) begin
         vld_d  = 1'b1;
         addr_d = line_align(sel_addr, OFFSET_W);
         we_d   = (grant == DC) && bus.dc_req_we_i;
         wd_d   = (grant == DC) ? bus.dc_req_wdata_i : '0;
         last_d = grant;
      end else if (bus.mem_req_ready_i) begin
         vld_d  = 1'b0;
         addr_d = '0;
         we_d   = 1'b0;
         wd_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
         we_q   <= 1'b0;
         wd_q   <= '0;
         last_q <= DC;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
         we_q   <= we_d;
         wd_q   <= wd_d;
         last_q <= last_d;
      end
   end

   id_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push),
      .push_id_i (grant),
      .pop_i     (pop),
      .head_o    (head),
      .empty_o   (empty),
      .count_o   (cnt)
   );

   always_comb begin
      ic_rv = 1'b0;
      dc_rv = 1'b0;
      mrr   = 1'b0;
      if (!empty) begin
         unique case (head)
            IC: begin
               ic_rv = bus.mem_resp_valid_i;
               mrr   = bus.ic_resp_ready_i;
            end
            DC: begin
               dc_rv = bus.mem_resp_valid_i;
               mrr   = bus.dc_resp_ready_i;
            end
            default: mrr = 1'b0;
         endcase
      end
   end

   assign pop = bus.mem_resp_valid_i && mrr;

   assign bus.ic_req_ready_o   = ic_rdy;
   assign bus.dc_req_ready_o   = dc_rdy;
   assign bus.ic_resp_valid_o  = ic_rv;
   assign bus.dc_resp_valid_o  = dc_rv;
   assign bus.ic_resp_data_o   = bus.mem_resp_data_i;
   assign bus.dc_resp_data_o   = bus.mem_resp_data_i;
   assign bus.mem_resp_ready_o = mrr;
   assign bus.mem_req_valid_o  = vld_q;
   assign bus.mem_req_addr_o   = addr_q;
   assign bus.mem_req_we_o     = we_q;
   assign bus.mem_req_wdata_o  = wd_q;
   assign bus.outst_cnt_o      = cnt;

   // A response with nothing outstanding is a memory-side protocol error.
   a_no_orphan_resp: assert property (
      @(posedge clk) disable iff (rst)
      !(bus.mem_resp_valid_i && empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 64;
   localparam int LW = 512;
   localparam int OW = 6;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW), .MAX_OUTST(MO)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .LINE_W(LW), .OFFSET_W(OW), .MAX_OUTST(MO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // stimulus state
   bit          ic_v, dc_v, dc_we, mrr, mrv, icrr, dcrr;
   logic [AW-1:0] ic_a, dc_a;
   logic [LW-1:0] dc_wd, mrd;

   // reference model: 0 = icache, 1 = dcache
   bit            m_vld, m_we;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wd;
   int            m_last;
   int            idq[$];
   int            mem_acc;
   bit            ic_fired, dc_fired, resp_popped;

   task automatic chk(input string tag, input logic [LW-1:0] obs,
                      input logic [LW-1:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic apply();
      bus.ic_req_valid_i   = ic_v;
      bus.ic_req_addr_i    = ic_a;
      bus.ic_resp_ready_i  = icrr;
      bus.dc_req_valid_i   = dc_v;
      bus.dc_req_addr_i    = dc_a;
      bus.dc_req_we_i      = dc_we;
      bus.dc_req_wdata_i   = dc_wd;
      bus.dc_resp_ready_i  = dcrr;
      bus.mem_req_ready_i  = mrr;
      bus.mem_resp_valid_i = mrv;
      bus.mem_resp_data_i  = mrd;
   endtask

   task automatic clear_all();
      ic_v = 0; dc_v = 0; dc_we = 0; mrr = 0; mrv = 0; icrr = 0; dcrr = 0;
      ic_a = '0; dc_a = '0; dc_wd = '0; mrd = '0;
      m_vld = 0; m_we = 0; m_addr = '0; m_wd = '0; m_last = 1;
      idq.delete(); mem_acc = 0;
      ic_fired = 0; dc_fired = 0; resp_popped = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_icrdy"}, bus.ic_req_ready_o, 0);
      chk({tag, "_dcrdy"}, bus.dc_req_ready_o, 0);
      chk({tag, "_icrv"}, bus.ic_resp_valid_o, 0);
      chk({tag, "_dcrv"}, bus.dc_resp_valid_o, 0);
      chk({tag, "_mrr"}, bus.mem_resp_ready_o, 0);
      chk({tag, "_mvld"}, bus.mem_req_valid_o, 0);
      chk({tag, "_maddr"}, bus.mem_req_addr_o, 0);
      chk({tag, "_mwe"}, bus.mem_req_we_o, 0);
      chk({tag, "_mwd"}, bus.mem_req_wdata_o, 0);
      chk({tag, "_cnt"}, bus.outst_cnt_o, 0);
   endtask

   task automatic step();
      int g, head;
      bit can, ic_rdy, dc_rdy, mrr_o, pop;
      @(negedge clk);
      apply();
      #1;
      can = (!m_vld || mrr) && (idq.size() < MO);
      if (ic_v && dc_v) g = (m_last == 1) ? 0 : 1;
      else              g = ic_v ? 0 : 1;
      ic_rdy = can && ic_v && g == 0;
      dc_rdy = can && dc_v && g == 1;
      head   = (idq.size() > 0) ? idq[0] : -1;
      mrr_o  = (head == 0 && icrr) || (head == 1 && dcrr);
      chk("ic_req_ready", bus.ic_req_ready_o, ic_rdy);
      chk("dc_req_ready", bus.dc_req_ready_o, dc_rdy);
      chk("mem_req_valid", bus.mem_req_valid_o, m_vld);
      chk("mem_req_addr", bus.mem_req_addr_o, m_addr);
      chk("mem_req_we", bus.mem_req_we_o, m_we);
      chk("mem_req_wdata", bus.mem_req_wdata_o, m_wd);
      chk("outst_cnt", bus.outst_cnt_o, idq.size());
      chk("ic_resp_valid", bus.ic_resp_valid_o, head == 0 && mrv);
      chk("dc_resp_valid", bus.dc_resp_valid_o, head == 1 && mrv);
      chk("mem_resp_ready", bus.mem_resp_ready_o, mrr_o);
      chk("ic_resp_data", bus.ic_resp_data_o, mrd);
      chk("dc_resp_data", bus.dc_resp_data_o, mrd);
      pop = mrv && mrr_o;
      ic_fired = ic_rdy;
      dc_fired = dc_rdy;
      resp_popped = pop;
      @(posedge clk);
      if (m_vld && mrr) mem_acc++;
      if (pop) begin
         void'(idq.pop_front());
         mem_acc--;
      end
      if (ic_rdy || dc_rdy) begin
         m_vld  = 1;
         m_addr = ((ic_rdy ? ic_a : dc_a) >> OW) << OW;
         m_we   = dc_rdy && dc_we;
         m_wd   = dc_rdy ? dc_wd : '0;
         idq.push_back(g);
         m_last = g;
      end else if (mrr) begin
         m_vld = 0; m_addr = '0; m_we = 0; m_wd = '0;
      end
   endtask

   task automatic rnd(input int pv, input int pmr, input int prv,
                      input int prr);
      if (!ic_v || ic_fired) begin
         ic_v = ($urandom_range(99) < pv);
         ic_a = {$urandom, $urandom};
      end
      if (!dc_v || dc_fired) begin
         dc_v  = ($urandom_range(99) < pv);
         dc_a  = {$urandom, $urandom};
         dc_we = $urandom_range(1);
         dc_wd = rand_line();
      end
      mrr = ($urandom_range(99) < pmr);
      if (!(mrv && !resp_popped)) begin
         mrv = (mem_acc > 0) && ($urandom_range(99) < prv);
         mrd = rand_line();
      end
      icrr = ($urandom_range(99) < prr);
      dcrr = ($urandom_range(99) < prr);
      step();
   endtask

   task automatic run(input int n, input int pv, input int pmr,
                      input int prv, input int prr);
      for (int i = 0; i < n; i++) rnd(pv, pmr, prv, prr);
   endtask

   initial begin
      rst = 1'b1;
      clear_all();
      apply();
      repeat (2) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // single icache miss, line-aligned, then its refill
      ic_v = 1; ic_a = 64'h8000_1234; mrr = 1; icrr = 1; dcrr = 1;
      step();
      #1;
      chk("dir_addr", bus.mem_req_addr_o, 64'h8000_1200);
      chk("dir_we", bus.mem_req_we_o, 0);
      chk("dir_cnt", bus.outst_cnt_o, 1);
      ic_v = 0;
      step();
      mrv = 1; mrd = {8{64'hAAAA_AAAA_AAAA_AAAA}};
      step();
      #1 chk("dir_cnt_pop", bus.outst_cnt_o, 0);
      mrv = 0;

      // no responses: occupancy must saturate at MAX_OUTST
      run(20, 100, 100, 0, 100);
      #1;
      chk("full_cnt", bus.outst_cnt_o, MO);
      chk("full_ic_rdy", bus.ic_req_ready_o, 0);
      chk("full_dc_rdy", bus.dc_req_ready_o, 0);

      run(300, 80, 100, 70, 80);
      run(300, 80, 40, 60, 50);

      // drive toward a busy state, then reset asynchronously
      for (int i = 0; i < 200; i++) begin
         if (idq.size() == 3 && m_vld) break;
         rnd(90, 60, 30, 60);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("mid_rst");
      clear_all();
      apply();
      @(negedge clk);
      rst = 1'b0;

      // after reset icache wins the first tie
      ic_v = 1; ic_a = 64'h1000_0040;
      dc_v = 1; dc_a = 64'h2000_0080; dc_we = 1; dc_wd = rand_line();
      mrr = 1; icrr = 1; dcrr = 1;
      step();
      #1;
      chk("post_rst_we", bus.mem_req_we_o, 0);
      chk("post_rst_addr", bus.mem_req_addr_o, 64'h1000_0040);

      run(400, 90, 70, 70, 70);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
